// File: rtl/shift_reg_universal.sv
// Universal shift register: DEPTH stages of WIDTH bits with shift, rotate,
// parallel load and clear, serial in/out at both ends and a saturating
// fill counter that tracks how many stages hold entered or loaded data.
module shift_reg_universal #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 3,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [2:0]             mode,
   input  logic [WIDTH-1:0]       sin_lo,
   input  logic [WIDTH-1:0]       sin_hi,
   input  logic [DEPTH*WIDTH-1:0] pdata,
   output logic [DEPTH*WIDTH-1:0] q,
   output logic [WIDTH-1:0]       sout_lo,
   output logic [WIDTH-1:0]       sout_hi,
   output logic [CW-1:0]          fill,
   output logic                   full
);

   localparam logic [2:0] MODE_SHIFT_UP = 3'b001;
   localparam logic [2:0] MODE_SHIFT_DN = 3'b010;
   localparam logic [2:0] MODE_ROT_UP   = 3'b011;
   localparam logic [2:0] MODE_ROT_DN   = 3'b100;
   localparam logic [2:0] MODE_LOAD     = 3'b101;
   localparam logic [2:0] MODE_CLEAR    = 3'b110;

   localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

   // Packed so that stage i occupies bits [i*WIDTH +: WIDTH], matching q/pdata.
   logic [DEPTH-1:0][WIDTH-1:0] stage_reg;
   logic [DEPTH-1:0][WIDTH-1:0] stage_next;
   logic [CW-1:0]               fill_reg;
   logic [CW-1:0]               fill_next;
   logic                        full_reg;
   logic                        full_next;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         // Neighbour indices with wrap-around; the wrapped value is only used
         // by the rotate modes, the shift modes substitute the serial input.
         localparam int BELOW = (gi == 0) ? DEPTH - 1 : gi - 1;
         localparam int ABOVE = (gi == DEPTH - 1) ? 0 : gi + 1;

         logic [WIDTH-1:0] shift_up_src;
         logic [WIDTH-1:0] shift_dn_src;
         logic [WIDTH-1:0] stage_nxt;

         assign shift_up_src = (gi == 0)         ? sin_lo : stage_reg[BELOW];
         assign shift_dn_src = (gi == DEPTH - 1) ? sin_hi : stage_reg[ABOVE];

         // Select this stage's next value from pre-edge register contents only.
         always_comb begin
            stage_nxt = stage_reg[gi];
            if (en) begin
               case (mode)
                  MODE_SHIFT_UP: stage_nxt = shift_up_src;
                  MODE_SHIFT_DN: stage_nxt = shift_dn_src;
                  MODE_ROT_UP:   stage_nxt = stage_reg[BELOW];
                  MODE_ROT_DN:   stage_nxt = stage_reg[ABOVE];
                  MODE_LOAD:     stage_nxt = pdata[gi*WIDTH +: WIDTH];
                  MODE_CLEAR:    stage_nxt = '0;
                  default:       stage_nxt = stage_reg[gi];
               endcase
            end
         end

         assign stage_next[gi] = stage_nxt;
      end
   endgenerate

   // Fill counter: serial entries saturate at DEPTH, rotates keep it, load fills, clear empties.
   always_comb begin
      fill_next = fill_reg;
      if (en) begin
         case (mode)
            MODE_SHIFT_UP,
            MODE_SHIFT_DN: begin
               if (fill_reg != FILL_MAX) begin
                  fill_next = fill_reg + CW'(1);
               end
            end
            MODE_LOAD:  fill_next = FILL_MAX;
            MODE_CLEAR: fill_next = '0;
            default:    fill_next = fill_reg;
         endcase
      end
      full_next = (fill_next == FILL_MAX);
   end

   // State registers; reset discards everything regardless of en/mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_reg <= '0;
         fill_reg  <= '0;
         full_reg  <= 1'b0;
      end else begin
         stage_reg <= stage_next;
         fill_reg  <= fill_next;
         full_reg  <= full_next;
      end
   end

   assign q       = stage_reg;
   assign sout_lo = stage_reg[0];
   assign sout_hi = stage_reg[DEPTH-1];
   assign fill    = fill_reg;
   assign full    = full_reg;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed bench for shift_reg_universal: a default 1x3 instance and an
// 8x4 instance, each checked against hand-computed expected values.
module tb_shift_reg_universal;

   logic clk;

   // Default configuration instance (WIDTH=1, DEPTH=3)
   logic       a_rst, a_en;
   logic [2:0] a_mode;
   logic       a_sin_lo, a_sin_hi;
   logic [2:0] a_pdata, a_q;
   logic       a_sout_lo, a_sout_hi;
   logic [1:0] a_fill;
   logic       a_full;

   // Byte-wide instance (WIDTH=8, DEPTH=4)
   logic        b_rst, b_en;
   logic [2:0]  b_mode;
   logic [7:0]  b_sin_lo, b_sin_hi;
   logic [31:0] b_pdata, b_q;
   logic [7:0]  b_sout_lo, b_sout_hi;
   logic [2:0]  b_fill;
   logic        b_full;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   shift_reg_universal dut_a (
      .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode),
      .sin_lo(a_sin_lo), .sin_hi(a_sin_hi), .pdata(a_pdata),
      .q(a_q), .sout_lo(a_sout_lo), .sout_hi(a_sout_hi),
      .fill(a_fill), .full(a_full)
   );

   shift_reg_universal #(.WIDTH(8), .DEPTH(4)) dut_b (
      .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode),
      .sin_lo(b_sin_lo), .sin_hi(b_sin_hi), .pdata(b_pdata),
      .q(b_q), .sout_lo(b_sout_lo), .sout_hi(b_sout_hi),
      .fill(b_fill), .full(b_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [2:0] eq, input logic [1:0] ef, input logic efull);
      logic [2:0] e;
      e = eq;
      $display("A %s: q=%b fill=%0d full=%0d", tag, a_q, a_fill, a_full);
      chk({tag, ".q"},       64'(a_q),       64'(e));
      chk({tag, ".fill"},    64'(a_fill),    64'(ef));
      chk({tag, ".full"},    64'(a_full),    64'(efull));
      chk({tag, ".sout_lo"}, 64'(a_sout_lo), 64'(e[0]));
      chk({tag, ".sout_hi"}, 64'(a_sout_hi), 64'(e[2]));
   endtask

   task automatic chk_b(input string tag, input logic [31:0] eq, input logic [2:0] ef, input logic efull);
      logic [31:0] e;
      e = eq;
      $display("B %s: q=%h fill=%0d full=%0d", tag, b_q, b_fill, b_full);
      chk({tag, ".q"},       64'(b_q),       64'(e));
      chk({tag, ".fill"},    64'(b_fill),    64'(ef));
      chk({tag, ".full"},    64'(b_full),    64'(efull));
      chk({tag, ".sout_lo"}, 64'(b_sout_lo), 64'(e[7:0]));
      chk({tag, ".sout_hi"}, 64'(b_sout_hi), 64'(e[31:24]));
   endtask

   initial begin
      a_rst = 1'b1; a_en = 1'b0; a_mode = 3'b000;
      a_sin_lo = 1'b0; a_sin_hi = 1'b0; a_pdata = 3'b000;
      b_rst = 1'b1; b_en = 1'b0; b_mode = 3'b000;
      b_sin_lo = 8'h00; b_sin_hi = 8'h00; b_pdata = 32'h0;

      // Reset both instances
      tick();
      chk_a("a_reset", 3'b000, 2'd0, 1'b0);
      chk_b("b_reset", 32'h0, 3'd0, 1'b0);
      a_rst = 1'b0; b_rst = 1'b0;

      // Default chain: shift up ones then zeros, fill saturates at 3
      a_en = 1'b1; a_mode = 3'b001; a_sin_lo = 1'b1;
      tick(); chk_a("a_up1", 3'b001, 2'd1, 1'b0);
      tick(); chk_a("a_up2", 3'b011, 2'd2, 1'b0);
      tick(); chk_a("a_up3", 3'b111, 2'd3, 1'b1);
      a_sin_lo = 1'b0;
      tick(); chk_a("a_up4", 3'b110, 2'd3, 1'b1);
      tick(); chk_a("a_up5", 3'b100, 2'd3, 1'b1);
      tick(); chk_a("a_up6", 3'b000, 2'd3, 1'b1);

      // Clear, refill to 111, then clear again
      a_mode = 3'b110;
      tick(); chk_a("a_clr1", 3'b000, 2'd0, 1'b0);
      a_mode = 3'b001; a_sin_lo = 1'b1;
      tick(); chk_a("a_refill1", 3'b001, 2'd1, 1'b0);
      tick(); chk_a("a_refill2", 3'b011, 2'd2, 1'b0);
      tick(); chk_a("a_refill3", 3'b111, 2'd3, 1'b1);
      a_mode = 3'b110; a_sin_lo = 1'b0;
      tick(); chk_a("a_clr2", 3'b000, 2'd0, 1'b0);

      // Load then rotate down twice, rotate up once
      a_mode = 3'b101; a_pdata = 3'b001;
      tick(); chk_a("a_load", 3'b001, 2'd3, 1'b1);
      a_mode = 3'b100; a_pdata = 3'b110;
      tick(); chk_a("a_rotdn1", 3'b100, 2'd3, 1'b1);
      tick(); chk_a("a_rotdn2", 3'b010, 2'd3, 1'b1);
      a_mode = 3'b011;
      tick(); chk_a("a_rotup1", 3'b100, 2'd3, 1'b1);

      // Shift down from empty, then an up shift still counts as an entry
      a_mode = 3'b110;
      tick(); chk_a("a_clr3", 3'b000, 2'd0, 1'b0);
      a_mode = 3'b010; a_sin_hi = 1'b1;
      tick(); chk_a("a_dn1", 3'b100, 2'd1, 1'b0);
      a_sin_hi = 1'b0;
      tick(); chk_a("a_dn2", 3'b010, 2'd2, 1'b0);
      a_mode = 3'b001; a_sin_lo = 1'b1;
      tick(); chk_a("a_alt_up", 3'b101, 2'd3, 1'b1);
      a_en = 1'b0;

      // Byte-wide: load then rotate up four times
      b_en = 1'b1; b_mode = 3'b101; b_pdata = 32'h44332211;
      tick(); chk_b("b_load", 32'h44332211, 3'd4, 1'b1);
      b_mode = 3'b011; b_pdata = 32'h0;
      tick(); chk_b("b_rot1", 32'h33221144, 3'd4, 1'b1);
      tick(); chk_b("b_rot2", 32'h22114433, 3'd4, 1'b1);
      tick(); chk_b("b_rot3", 32'h11443322, 3'd4, 1'b1);
      tick(); chk_b("b_rot4", 32'h44332211, 3'd4, 1'b1);

      // Clear then shift down four bytes, one more saturates fill
      b_mode = 3'b110;
      tick(); chk_b("b_clr", 32'h0, 3'd0, 1'b0);
      b_mode = 3'b010; b_sin_hi = 8'hA1;
      tick(); chk_b("b_dn1", 32'hA1000000, 3'd1, 1'b0);
      b_sin_hi = 8'hB2;
      tick(); chk_b("b_dn2", 32'hB2A10000, 3'd2, 1'b0);
      b_sin_hi = 8'hC3;
      tick(); chk_b("b_dn3", 32'hC3B2A100, 3'd3, 1'b0);
      b_sin_hi = 8'hD4;
      tick(); chk_b("b_dn4", 32'hD4C3B2A1, 3'd4, 1'b1);
      b_sin_hi = 8'hE5;
      tick(); chk_b("b_dn5", 32'hE5D4C3B2, 3'd4, 1'b1);

      // Load, then hold with en=0, reserved mode 111 and mode 000
      b_mode = 3'b101; b_pdata = 32'h44332211;
      tick(); chk_b("b_load2", 32'h44332211, 3'd4, 1'b1);
      b_en = 1'b0; b_mode = 3'b001; b_sin_lo = 8'hFF; b_pdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         tick(); chk_b("b_hold_en0", 32'h44332211, 3'd4, 1'b1);
      end
      b_en = 1'b1; b_mode = 3'b111;
      tick(); chk_b("b_hold_m7a", 32'h44332211, 3'd4, 1'b1);
      tick(); chk_b("b_hold_m7b", 32'h44332211, 3'd4, 1'b1);
      b_mode = 3'b000;
      tick(); chk_b("b_hold_m0", 32'h44332211, 3'd4, 1'b1);

      // Reset mid-shift wins over a simultaneous load
      b_mode = 3'b110;
      tick(); chk_b("b_clr2", 32'h0, 3'd0, 1'b0);
      b_mode = 3'b001; b_sin_lo = 8'h55;
      tick(); chk_b("b_up1", 32'h00000055, 3'd1, 1'b0);
      b_sin_lo = 8'h66;
      tick(); chk_b("b_up2", 32'h00005566, 3'd2, 1'b0);
      b_rst = 1'b1; b_mode = 3'b101; b_pdata = 32'hDEADBEEF;
      tick(); chk_b("b_rst_vs_load", 32'h0, 3'd0, 1'b0);
      b_rst = 1'b0; b_mode = 3'b110;
      tick(); chk_b("b_clr_after_rst", 32'h0, 3'd0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised universal shift register: DEPTH stages, each WIDTH bits wide.
- Modes: hold, shift up, shift down, rotate up, rotate down, parallel load, clear.
- Adds serial-in/serial-out at both ends, plus a fill counter showing how many stages hold serially-entered or loaded data.
- Generic delay-line / serialiser building block. The default configuration (WIDTH=1, DEPTH=3) is cycle-equivalent to a 3-bit nonblocking shift chain: stage0 <= d, stage1 <= stage0, stage2 <= stage1.

Parameters:
WIDTH, 1, bits per stage (>=1)
DEPTH, 3, number of stages (>=2)
CW, $clog2(DEPTH+1), fill counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  clock enable; 0 forces hold regardless of mode
mode  input  3  operation select (see Behaviour)
sin_lo  input  WIDTH  serial input into stage 0 (shift up)
sin_hi  input  WIDTH  serial input into stage DEPTH-1 (shift down)
pdata  input  DEPTH*WIDTH  parallel load data; stage i = pdata[i*WIDTH +: WIDTH]
q  output  DEPTH*WIDTH  all stages; stage i = q[i*WIDTH +: WIDTH]
sout_lo  output  WIDTH  stage 0 (equals q[WIDTH-1:0])
sout_hi  output  WIDTH  stage DEPTH-1
fill  output  CW  valid-stage count, 0..DEPTH
full  output  1  registered; 1 iff fill==DEPTH

Behaviour:
- Clocking and update rule:
  - All state updates on the rising edge of clk.
  - Every stage is updated from the pre-edge values of all stages (true register semantics). No stage sees another stage's same-cycle update.
- Reset:
  - rst=1 at an edge gives q=0, fill=0, full=0.
  - rst has priority over en and mode.
  - Reset mid-operation discards all contents on that edge.
- Hold: en=0, or mode 3'b000 or 3'b111 (reserved). q, fill and full are unchanged.
- 3'b001 shift up:
  - stage0 <= sin_lo; stage i <= stage i-1 for i=1..DEPTH-1.
  - The old stage DEPTH-1 is lost. It was visible on sout_hi before the edge.
  - fill <= min(fill+1, DEPTH).
- 3'b010 shift down:
  - stage DEPTH-1 <= sin_hi; stage i <= stage i+1 for i=0..DEPTH-2.
  - The old stage0 is lost.
  - fill <= min(fill+1, DEPTH).
- 3'b011 rotate up: stage0 <= old stage DEPTH-1; stage i <= stage i-1. fill unchanged.
- 3'b100 rotate down: stage DEPTH-1 <= old stage0; stage i <= stage i+1. fill unchanged.
- 3'b101 parallel load: q <= pdata; fill <= DEPTH.
- 3'b110 clear: q <= 0; fill <= 0. Same effect as reset, but qualified by en.
- fill rules:
  - Saturates at DEPTH and never wraps.
  - full is registered together with fill, so it asserts on the same edge fill reaches DEPTH.
  - Alternating up/down shifts still increment fill. fill counts entries, not direction.
- Latency:
  - A serial input appears on q one cycle after its edge.
  - With en=1 and continuous shift up, sin_lo reaches sout_hi after DEPTH edges.
- Outputs:
  - q, sout_lo and sout_hi are direct register outputs, with no combinational path from any input.
  - sout_lo and sout_hi are always consistent with q.
- Inputs are sampled only at the edge. sin_lo, sin_hi and pdata are don't-care in modes that do not use them.

Test Plan:
- Defaults; rst=1 for one edge, then en=1, mode=001, sin_lo=1 for 3 edges, then sin_lo=0 for 3 edges:
  - q = 001, 011, 111, 110, 100, 000 on successive edges.
  - fill = 1, 2, 3, 3, 3, 3; full=1 from the 3rd edge.
- WIDTH=8, DEPTH=4; load pdata=0x44332211, then rotate up x4:
  - q = 0x33221144, 0x22114433, 0x11443322, 0x44332211.
  - fill=4 throughout.
- WIDTH=8, DEPTH=4; shift down with sin_hi = 0xA1, 0xB2, 0xC3, 0xD4:
  - q = 0xD4C3B2A1 after 4 edges; sout_lo=0xA1.
  - fill 1..4, full asserted on the 4th edge.
- Load 0x44332211, then mode=001 with en=0 for 5 edges: q, fill and full are unchanged. mode=111 with en=1 behaves the same.
- Mid-shift (fill=2), assert rst with mode=101 and pdata nonzero on the same edge: q=0, fill=0, full=0, so reset wins over load. Next edge with clear mode keeps everything at 0.
- Defaults; after q=111 and full=1, apply mode=110 with en=1: q=000, fill=0, full=0 on that edge.
